alu_result_wb: RTL and testbench

Writeback end of the 8-bit ALU datapath. It accepts 16-bit ALU results over a valid/ready handshake and buffers them in a small FIFO. Each result is written as two 8-bit bytes into an 8-bit register bank through a single write port. Two combinational read ports supply operand bytes back to the operand-fetch side.

---
 rtl/alu_pkg.sv | 23 ++
 rtl/alu_wb_fifo.sv | 64 ++++++
 rtl/alu_result_wb.sv | 139 +++++++++++++
 tb/tb_alu_result_wb.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared types and constants for the ALU result writeback block
package alu_pkg;

    // Width of one register-bank byte
    localparam int BYTE_W = 8;

    // Widest destination index an entry can carry; the top uses the low bits
    localparam int DST_W = 8;

    // Writeback FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WR_HI = 2'd1,
        WR_LO = 2'd2
    } wb_state_t;

    // One buffered ALU result: hi-byte destination plus the 16-bit value
    typedef struct packed {
        logic [DST_W-1:0]    dst;
        logic [2*BYTE_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/alu_wb_fifo.sv
// rtl/alu_wb_fifo.sv - synchronous result FIFO with occupancy count
import alu_pkg::*;

module alu_wb_fifo #(
    parameter int  DEPTH   = 2,
    parameter type entry_t = wb_entry_t
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  entry_t                   push_data,
    input  logic                     pop,
    output entry_t                   head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    entry_t          mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    // Guard against overflow/underflow regardless of what the caller asserts
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    // Entry storage; contents are don't-care while the slot is unoccupied
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/alu_result_wb.sv
// rtl/alu_result_wb.sv - ALU result writeback FSM, register bank and read ports (optional ALU_WB_BYPASS_EN)
import alu_pkg::*;

module alu_result_wb #(
    parameter int NREGS = 8,
    parameter int DEPTH = 2
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       res_valid,
    output logic                       res_ready,
    input  logic [2*BYTE_W-1:0]        res_data,
    input  logic [$clog2(NREGS)-1:0]   res_dst,
    input  logic [$clog2(NREGS)-1:0]   rd_addr_a,
    input  logic [$clog2(NREGS)-1:0]   rd_addr_b,
    output logic [BYTE_W-1:0]          rd_a,
    output logic [BYTE_W-1:0]          rd_b,
    output logic [$clog2(DEPTH):0]     pending,
    output logic                       busy
);

    localparam int AW = $clog2(NREGS);
    localparam int CW = $clog2(DEPTH) + 1;

    wb_state_t          state_q;
    wb_state_t          state_d;
    wb_entry_t          push_entry;
    wb_entry_t          head;
    logic               push;
    logic               pop;
    logic               full;
    logic               empty;
    logic [CW-1:0]      count;
    logic [AW-1:0]      hi_addr;
    logic               wr_en;
    logic [AW-1:0]      wr_addr;
    logic [BYTE_W-1:0]  wr_byte;
    logic [BYTE_W-1:0]  bank [NREGS];
    logic               unused_dst_hi;

    // No pop lookahead: a full FIFO refuses even when the head is leaving
    assign res_ready = !full && !reset;
    assign push      = res_valid && res_ready;

    assign push_entry.dst  = DST_W'(res_dst);
    assign push_entry.data = res_data;

    alu_wb_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (wb_entry_t)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    assign hi_addr       = head.dst[AW-1:0];
    assign unused_dst_hi = &{1'b0, head.dst};

    // FSM state register; reset discards any half-written entry
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and the single bank write port
    always_comb begin
        state_d = state_q;
        wr_en   = 1'b0;
        wr_addr = hi_addr;
        wr_byte = head.data[2*BYTE_W-1:BYTE_W];
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    state_d = WR_HI;
                end
            end
            WR_HI: begin
                wr_en   = 1'b1;
                state_d = WR_LO;
            end
            WR_LO: begin
                wr_en   = 1'b1;
                wr_addr = hi_addr + AW'(1);
                wr_byte = head.data[BYTE_W-1:0];
                pop     = 1'b1;
                // Something remains once the head leaves: another entry or a same-edge push
                if ((count > CW'(1)) || push) begin
                    state_d = WR_HI;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Register bank, cleared by reset
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                bank[i] <= '0;
            end
        end else if (wr_en) begin
            bank[wr_addr] <= wr_byte;
        end
    end

    // Combinational read ports, optionally forwarding the byte being written
    always_comb begin
        rd_a = bank[rd_addr_a];
        rd_b = bank[rd_addr_b];
`ifdef ALU_WB_BYPASS_EN
        if (wr_en && (wr_addr == rd_addr_a)) begin
            rd_a = wr_byte;
        end
        if (wr_en && (wr_addr == rd_addr_b)) begin
            rd_b = wr_byte;
        end
`else
`endif
    end

    assign pending = count;
    assign busy    = (state_q != IDLE) || !empty;

endmodule

// File: tb/tb_alu_result_wb.sv
// tb/tb_alu_result_wb.sv - directed self-checking bench for alu_result_wb
module tb_alu_result_wb;

    logic        clock;
    logic        reset;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic [2:0]  res_dst;
    logic [2:0]  rd_addr_a;
    logic [2:0]  rd_addr_b;
    logic [7:0]  rd_a;
    logic [7:0]  rd_b;
    logic [1:0]  pending;
    logic        busy;

    int n_checks;
    int n_fail;

    alu_result_wb #(.NREGS(8), .DEPTH(2)) dut (
        .clock     (clock),
        .reset     (reset),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_dst   (res_dst),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .rd_a      (rd_a),
        .rd_b      (rd_b),
        .pending   (pending),
        .busy      (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        reset     = 1'b1;
        res_valid = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    // Offer one result for a single cycle; caller knows the FIFO has room
    task automatic push_one(input logic [15:0] d, input logic [2:0] dst);
        res_valid = 1'b1;
        res_data  = d;
        res_dst   = dst;
        step();
        res_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        n_checks++;
        if (res_ready !== 1'b0) begin
            $display("FAIL reset_ready_low: got %0b want 0", res_ready);
            n_fail++;
        end
        reset = 1'b0;
        #1;
        for (int i = 0; i < 8; i++) begin
            rd_addr_a = 3'(i);
            rd_addr_b = 3'(7 - i);
            #1;
            n_checks++;
            if (rd_a !== 8'h00 || rd_b !== 8'h00) begin
                $display("FAIL reset_bank[%0d]: got a=%h b=%h want 00", i, rd_a, rd_b);
                n_fail++;
            end
        end
        step();
        n_checks++;
        if (pending !== 2'd0 || res_ready !== 1'b1 || busy !== 1'b0) begin
            $display("FAIL reset_idle: got pending=%0d ready=%0b busy=%0b want 0 1 0",
                     pending, res_ready, busy);
            n_fail++;
        end
    endtask

    task automatic test_single();
        rd_addr_a = 3'd3;
        rd_addr_b = 3'd4;
        push_one(16'hA55A, 3'd3);          // edge N
        n_checks++;
        if (pending !== 2'd1 || busy !== 1'b1) begin
            $display("FAIL single_accept: got pending=%0d busy=%0b want 1 1", pending, busy);
            n_fail++;
        end
        step();                            // N+1: WR_HI
        step();                            // N+2: hi byte written
        n_checks++;
        if (rd_a !== 8'hA5) begin
            $display("FAIL single_hi: got %h want a5", rd_a);
            n_fail++;
        end
        n_checks++;
        if (busy !== 1'b1 || pending !== 2'd1) begin
            $display("FAIL single_mid_busy: got busy=%0b pending=%0d want 1 1", busy, pending);
            n_fail++;
        end
        step();                            // N+3: lo byte written, popped
        n_checks++;
        if (rd_b !== 8'h5A) begin
            $display("FAIL single_lo: got %h want 5a", rd_b);
            n_fail++;
        end
        n_checks++;
        if (busy !== 1'b0 || pending !== 2'd0) begin
            $display("FAIL single_done: got busy=%0b pending=%0d want 0 0", busy, pending);
            n_fail++;
        end
    endtask

    task automatic test_wrap();
        push_one(16'h1234, 3'd7);
        step();
        step();
        step();
        rd_addr_a = 3'd7;
        rd_addr_b = 3'd0;
        #1;
        n_checks++;
        if (rd_a !== 8'h12 || rd_b !== 8'h34) begin
            $display("FAIL wrap: got reg7=%h reg0=%h want 12 34", rd_a, rd_b);
            n_fail++;
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] vals [4];
        logic [2:0]  dsts [4];
        logic [7:0]  exp_bank [8];
        int          idx;
        int          cyc;
        int          max_pend;
        int          bad_ready;
        vals[0] = 16'h0102; dsts[0] = 3'd0;
        vals[1] = 16'h0304; dsts[1] = 3'd2;
        vals[2] = 16'h0506; dsts[2] = 3'd4;
        vals[3] = 16'h0708; dsts[3] = 3'd6;
        for (int i = 0; i < 8; i++) exp_bank[i] = 8'(i + 1);
        apply_reset();
        idx       = 0;
        cyc       = 0;
        max_pend  = 0;
        bad_ready = 0;
        while (idx < 4 && cyc < 100) begin
            res_valid = 1'b1;
            res_data  = vals[idx];
            res_dst   = dsts[idx];
            #1;
            if (int'(pending) > max_pend) max_pend = int'(pending);
            if (pending == 2'd2 && res_ready) bad_ready++;
            if (pending != 2'd2 && !res_ready) bad_ready++;
            if (res_ready) idx++;
            step();
            cyc++;
        end
        res_valid = 1'b0;
        n_checks++;
        if (idx != 4) begin
            $display("FAIL b2b_accept: got %0d accepted want 4 within budget", idx);
            n_fail++;
        end
        n_checks++;
        if (max_pend != 2) begin
            $display("FAIL b2b_fill: got max pending %0d want 2", max_pend);
            n_fail++;
        end
        n_checks++;
        if (bad_ready != 0) begin
            $display("FAIL b2b_ready: got %0d cycles with ready!=(pending<2) want 0", bad_ready);
            n_fail++;
        end
        cyc = 0;
        while (busy && cyc < 50) begin
            step();
            cyc++;
        end
        n_checks++;
        if (busy !== 1'b0) begin
            $display("FAIL b2b_drain: got busy=%0b want 0 within 50 cycles", busy);
            n_fail++;
        end
        for (int i = 0; i < 8; i++) begin
            rd_addr_a = 3'(i);
            #1;
            n_checks++;
            if (rd_a !== exp_bank[i]) begin
                $display("FAIL b2b_bank[%0d]: got %h want %h", i, rd_a, exp_bank[i]);
                n_fail++;
            end
        end
    endtask

    task automatic test_bypass();
        logic [7:0] exp_first;
`ifdef ALU_WB_BYPASS_EN
        exp_first = 8'hA5;
`else
        exp_first = 8'h00;
`endif
        apply_reset();
        rd_addr_a = 3'd3;
        push_one(16'hA55A, 3'd3);          // edge N
        step();                            // N+1: WR_HI, reg3 being written
        n_checks++;
        if (rd_a !== exp_first) begin
            $display("FAIL bypass_same_cycle: got %h want %h", rd_a, exp_first);
            n_fail++;
        end
        step();                            // N+2: write landed
        n_checks++;
        if (rd_a !== 8'hA5) begin
            $display("FAIL bypass_next_cycle: got %h want a5", rd_a);
            n_fail++;
        end
        step();
    endtask

    task automatic test_reset_mid();
        push_one(16'hFFEE, 3'd1);          // edge N
        step();                            // N+1: WR_HI
        step();                            // N+2: in WR_LO, reg1 = FF
        rd_addr_a = 3'd1;
        rd_addr_b = 3'd2;
        #1;
        n_checks++;
        if (rd_a !== 8'hFF) begin
            $display("FAIL mid_hi_written: got %h want ff", rd_a);
            n_fail++;
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if (rd_a !== 8'h00 || rd_b !== 8'h00) begin
            $display("FAIL mid_cleared: got reg1=%h reg2=%h want 00 00", rd_a, rd_b);
            n_fail++;
        end
        n_checks++;
        if (pending !== 2'd0 || busy !== 1'b0) begin
            $display("FAIL mid_idle: got pending=%0d busy=%0b want 0 0", pending, busy);
            n_fail++;
        end
        step();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) step();
        n_checks++;
        if (rd_b !== 8'h00 || rd_a !== 8'h00 || busy !== 1'b0) begin
            $display("FAIL mid_no_late_write: got reg1=%h reg2=%h busy=%0b want 00 00 0",
                     rd_a, rd_b, busy);
            n_fail++;
        end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        reset     = 1'b1;
        res_valid = 1'b0;
        res_data  = 16'h0;
        res_dst   = 3'd0;
        rd_addr_a = 3'd0;
        rd_addr_b = 3'd0;
        test_reset();
        test_single();
        test_wrap();
        test_back_to_back();
        test_bypass();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
